// File: rtl/conv_pkg.sv
// Shared encodings for the conv controller slice: para-loader FSM states and
// the controller's start-pulse codes.
package conv_pkg;

  typedef enum logic [1:0] {
    PL_IDLE = 2'd0,
    PL_LOAD = 2'd1,
    PL_DONE = 2'd2
  } pl_state_e;

  localparam logic [3:0] SIGN_PARA    = 4'b0001;
  localparam logic [3:0] SIGN_COMPUTE = 4'b0010;

endpackage

// File: rtl/conv_para_cksum.sv
// 32-bit wrap-around accumulator with synchronous clear and enable; sums the
// low words of a parameter transfer for firmware-side verification.
module conv_para_cksum (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [31:0] add_i,
  output logic [31:0] sum_o
);

  logic [31:0] sum_q;
  logic [31:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i)     sum_d = '0;
    else if (en_i) sum_d = sum_q + add_i;
  end

  always_ff @(posedge clk) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/conv_para_loader.sv
// Parameter-load stage: on a Para start, streams Para_Len DMA words into the
// weight/bias buffer and pulses Para_Done. CONV_PARA_CKSUM_EN adds Para_Sum.
//
// state   | meaning
// PL_IDLE | waiting for Sign==SIGN_PARA
// PL_LOAD | S_Ready high, accepting one word per beat
// PL_DONE | single cycle after the last beat; Para_Done follows
module conv_para_loader
  import conv_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        Sign,
  input  logic [ADDR_W:0]   Para_Len,
  input  logic [DATA_W-1:0] S_Data,
  input  logic              S_Valid,
  output logic              S_Ready,
  output logic              Wr_En,
  output logic [ADDR_W-1:0] Wr_Addr,
  output logic [DATA_W-1:0] Wr_Data,
  output logic              Para_Done,
  output logic              Busy,
  output logic              Len_Err
`ifdef CONV_PARA_CKSUM_EN
  ,
  output logic [31:0]       Para_Sum
`endif
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  pl_state_e         state_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              ready_q;
  logic              busy_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              done_q;
  logic              len_err_q;

  logic [ADDR_W:0]   len_d;
  logic [ADDR_W-1:0] cnt_d;
  logic              start;
  logic              beat;
  logic              last_beat;

  assign start     = (state_q == PL_IDLE) && (Sign == SIGN_PARA);
  // ready_q is only ever high in PL_LOAD, so no path from S_Valid to S_Ready
  assign beat      = S_Valid && ready_q;
  assign len_d     = (Para_Len > DEPTH) ? DEPTH : Para_Len;
  assign last_beat = ({1'b0, cnt_q} == (len_q - 1'b1));
  assign cnt_d     = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PL_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        PL_IDLE: begin
          if (start) begin
            len_q     <= len_d;
            cnt_q     <= '0;
            len_err_q <= (Para_Len > DEPTH);
            busy_q    <= 1'b1;
            if (len_d == '0) begin
              state_q <= PL_DONE;
              ready_q <= 1'b0;
            end else begin
              state_q <= PL_LOAD;
              ready_q <= 1'b1;
            end
          end
        end
        PL_LOAD: begin
          if (beat) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= cnt_q;
            wr_data_q <= S_Data;
            // count holds at len-1 on the last beat so it never wraps
            if (last_beat) begin
              state_q <= PL_DONE;
              ready_q <= 1'b0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        PL_DONE: begin
          state_q <= PL_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= PL_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign S_Ready   = ready_q;
  assign Wr_En     = wr_en_q;
  assign Wr_Addr   = wr_addr_q;
  assign Wr_Data   = wr_data_q;
  assign Para_Done = done_q;
  assign Busy      = busy_q;
  assign Len_Err   = len_err_q;

`ifdef CONV_PARA_CKSUM_EN
  conv_para_cksum u_cksum (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start),
    .en_i  (beat),
    .add_i (S_Data[31:0]),
    .sum_o (Para_Sum)
  );
`endif

endmodule

// File: tb/tb_conv_para_loader.sv
// Directed bench for conv_para_loader; a negedge logger records beats, writes
// and done pulses, and each scenario task checks them against hand-derived values.
module tb_conv_para_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  Sign;
  logic [12:0] Para_Len;
  logic [63:0] S_Data;
  logic        S_Valid;
  logic        S_Ready;
  logic        Wr_En;
  logic [11:0] Wr_Addr;
  logic [63:0] Wr_Data;
  logic        Para_Done;
  logic        Busy;
  logic        Len_Err;
`ifdef CONV_PARA_CKSUM_EN
  logic [31:0] Para_Sum;
  logic [31:0] sum_at_done;
`endif

  conv_para_loader #(.DATA_W(64), .ADDR_W(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .Sign      (Sign),
    .Para_Len  (Para_Len),
    .S_Data    (S_Data),
    .S_Valid   (S_Valid),
    .S_Ready   (S_Ready),
    .Wr_En     (Wr_En),
    .Wr_Addr   (Wr_Addr),
    .Wr_Data   (Wr_Data),
    .Para_Done (Para_Done),
    .Busy      (Busy),
    .Len_Err   (Len_Err)
`ifdef CONV_PARA_CKSUM_EN
    ,
    .Para_Sum  (Para_Sum)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          t_start;
  int          busy_low;
  int          beat_cyc[$];
  logic [11:0] wa[$];
  logic [63:0] wd[$];
  int          wc[$];
  int          done_cyc[$];
  logic [63:0] dq[$];
  logic [3:0]  inj_sign[16];
  logic [12:0] inj_len;

  always @(negedge clk) begin
    if (S_Valid && S_Ready) beat_cyc.push_back(cyc);
    if (Wr_En) begin
      wa.push_back(Wr_Addr);
      wd.push_back(Wr_Data);
      wc.push_back(cyc);
    end
    if (Para_Done) begin
      done_cyc.push_back(cyc);
`ifdef CONV_PARA_CKSUM_EN
      sum_at_done = Para_Sum;
`endif
    end
  end

  task automatic clear_logs();
    beat_cyc.delete();
    wa.delete();
    wd.delete();
    wc.delete();
    done_cyc.delete();
    dq.delete();
    for (int i = 0; i < 16; i++) inj_sign[i] = 4'b0;
    inj_len = '0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input logic [12:0] len);
    Sign     = 4'b0001;
    Para_Len = len;
    t_start  = cyc;
    tick(1);
    Sign     = 4'b0000;
    Para_Len = '0;
  endtask

  task automatic feed(input int ncyc, input logic [63:0] vmask, input logic vrest);
    int idx;
    idx = 0;
    for (int i = 0; i < ncyc; i++) begin
      S_Valid  = (i < 64) ? vmask[i] : vrest;
      S_Data   = (idx < dq.size()) ? dq[idx] : (64'hDEAD_0000_0000_0000 + 64'(i));
      Sign     = (i < 16) ? inj_sign[i] : 4'b0000;
      Para_Len = inj_len;
      if (Busy !== 1'b1) busy_low++;
      if (S_Valid && S_Ready) idx++;
      tick(1);
    end
    S_Valid  = 1'b0;
    Sign     = 4'b0000;
    Para_Len = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    n_tests++;
    if ({S_Ready, Wr_En, Para_Done, Busy, Len_Err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 00000", {S_Ready, Wr_En, Para_Done, Busy, Len_Err});
    end
    n_tests++;
    if (Wr_Addr !== 12'h0 || Wr_Data !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_wr: got addr %h data %h want 0 0", Wr_Addr, Wr_Data);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_basic();
    clear_logs();
    for (int i = 1; i <= 4; i++) dq.push_back(64'(i));
    start(13'd4);
    feed(8, '1, 1'b1);
    n_tests++;
    if (beat_cyc.size() != 4) begin
      n_fail++;
      $display("FAIL t1_beats: got %0d want 4", beat_cyc.size());
    end
    n_tests++;
    if (wa.size() != 4) begin
      n_fail++;
      $display("FAIL t1_writes: got %0d want 4", wa.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (wa[i] !== 12'(i) || wd[i] !== 64'(i + 1) || wc[i] != t_start + 2 + i) begin
          n_fail++;
          $display("FAIL t1_write%0d: got a=%0d d=%0d c=%0d want a=%0d d=%0d c=%0d",
                   i, wa[i], wd[i], wc[i] - t_start, i, i + 1, 2 + i);
        end
      end
    end
    n_tests++;
    if (done_cyc.size() != 1 || done_cyc[0] != t_start + 6) begin
      n_fail++;
      $display("FAIL t1_done: got n=%0d c=%0d want n=1 c=6", done_cyc.size(),
               (done_cyc.size() > 0) ? done_cyc[0] - t_start : -1);
    end
`ifdef CONV_PARA_CKSUM_EN
    n_tests++;
    if (sum_at_done !== 32'd10) begin
      n_fail++;
      $display("FAIL t1_sum: got %h want 0000000a", sum_at_done);
    end
`endif
  endtask

  task automatic test_gaps();
    clear_logs();
    dq.push_back(64'h10);
    dq.push_back(64'h20);
    dq.push_back(64'h30);
    start(13'd3);
    busy_low = 0;
    feed(6, 64'b101001, 1'b0);
    n_tests++;
    if (Busy !== 1'b1 || busy_low != 0) begin
      n_fail++;
      $display("FAIL t2_busy: got busy=%b low_cycles=%0d want 1 0", Busy, busy_low);
    end
    tick(4);
    n_tests++;
    if (wa.size() != 3) begin
      n_fail++;
      $display("FAIL t2_writes: got %0d want 3", wa.size());
    end else begin
      n_tests++;
      if (wa[0] !== 12'd0 || wa[1] !== 12'd1 || wa[2] !== 12'd2 ||
          wd[2] !== 64'h30 || wc[0] != t_start + 2 || wc[1] != t_start + 5 || wc[2] != t_start + 7) begin
        n_fail++;
        $display("FAIL t2_order: got a=%0d,%0d,%0d c=%0d,%0d,%0d want a=0,1,2 c=2,5,7",
                 wa[0], wa[1], wa[2], wc[0] - t_start, wc[1] - t_start, wc[2] - t_start);
      end
    end
    n_tests++;
    if (done_cyc.size() != 1 || done_cyc[0] != t_start + 8) begin
      n_fail++;
      $display("FAIL t2_done: got n=%0d want 1 at cycle 8", done_cyc.size());
    end
  endtask

  task automatic test_zero_len();
    clear_logs();
    start(13'd0);
    feed(5, '1, 1'b1);
    n_tests++;
    if (beat_cyc.size() != 0 || wa.size() != 0) begin
      n_fail++;
      $display("FAIL t3_nowrite: got beats=%0d writes=%0d want 0 0", beat_cyc.size(), wa.size());
    end
    n_tests++;
    if (done_cyc.size() != 1 || done_cyc[0] != t_start + 2) begin
      n_fail++;
      $display("FAIL t3_done: got n=%0d want 1 at cycle 2", done_cyc.size());
    end
  endtask

  task automatic test_over_len();
    int errs;
    clear_logs();
    for (int i = 0; i < 4096; i++) dq.push_back(64'(i * 3 + 7));
    start(13'd4101);
    n_tests++;
    if (Len_Err !== 1'b1) begin
      n_fail++;
      $display("FAIL t4_len_err_set: got %b want 1", Len_Err);
    end
    feed(4100, '1, 1'b1);
    n_tests++;
    if (wa.size() != 4096 || beat_cyc.size() != 4096) begin
      n_fail++;
      $display("FAIL t4_count: got writes=%0d beats=%0d want 4096", wa.size(), beat_cyc.size());
    end else begin
      errs = 0;
      for (int i = 0; i < 4096; i++)
        if (wa[i] !== 12'(i) || wd[i] !== 64'(i * 3 + 7)) errs++;
      n_tests++;
      if (errs != 0 || wa[4095] !== 12'd4095) begin
        n_fail++;
        $display("FAIL t4_seq: got %0d bad writes last=%0d want 0 4095", errs, wa[4095]);
      end
    end
    n_tests++;
    if (done_cyc.size() != 1 || done_cyc[0] != t_start + 4098) begin
      n_fail++;
      $display("FAIL t4_done: got n=%0d want 1 at cycle 4098", done_cyc.size());
    end
    n_tests++;
    if (Len_Err !== 1'b1) begin
      n_fail++;
      $display("FAIL t4_len_err_sticky: got %b want 1", Len_Err);
    end
    clear_logs();
    dq.push_back(64'h55);
    start(13'd1);
    n_tests++;
    if (Len_Err !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_len_err_clr: got %b want 0", Len_Err);
    end
    feed(4, '1, 1'b1);
    n_tests++;
    if (wa.size() != 1 || wa[0] !== 12'd0 || wd[0] !== 64'h55) begin
      n_fail++;
      $display("FAIL t4_single: got n=%0d want 1 write at addr 0", wa.size());
    end
  endtask

  task automatic test_reset_abort();
    clear_logs();
    start(13'd8);
    feed(2, '1, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(4);
    n_tests++;
    if (done_cyc.size() != 0 || Busy !== 1'b0 || S_Ready !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_abort: got done=%0d busy=%b ready=%b want 0 0 0", done_cyc.size(), Busy, S_Ready);
    end
    clear_logs();
    dq.push_back(64'hA0);
    dq.push_back(64'hA1);
    start(13'd2);
    feed(6, '1, 1'b1);
    n_tests++;
    if (wa.size() != 2 || wa[0] !== 12'd0 || wa[1] !== 12'd1 || wd[1] !== 64'hA1) begin
      n_fail++;
      $display("FAIL t5_reload: got n=%0d want 2 writes at addr 0,1", wa.size());
    end
    n_tests++;
    if (done_cyc.size() != 1 || done_cyc[0] != t_start + 4) begin
      n_fail++;
      $display("FAIL t5_done: got n=%0d want 1 at cycle 4", done_cyc.size());
    end
  endtask

  task automatic test_sign_during_load();
    clear_logs();
    dq.push_back(64'h0000_0000_FFFF_FFFF);
    dq.push_back(64'h2);
    inj_len     = 13'd7;
    inj_sign[1] = 4'b0001;
    inj_sign[2] = 4'b0010;
    start(13'd2);
    feed(8, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
    n_tests++;
    if (beat_cyc.size() != 2 || wa.size() != 2) begin
      n_fail++;
      $display("FAIL t6_len_kept: got beats=%0d writes=%0d want 2 2", beat_cyc.size(), wa.size());
    end
    n_tests++;
    if (done_cyc.size() != 1 || done_cyc[0] != t_start + 5) begin
      n_fail++;
      $display("FAIL t6_done: got n=%0d want 1 at cycle 5", done_cyc.size());
    end
    n_tests++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_idle: got busy=%b want 0", Busy);
    end
`ifdef CONV_PARA_CKSUM_EN
    n_tests++;
    if (sum_at_done !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL t6_sum: got %h want 00000001", sum_at_done);
    end
`endif
  endtask

  initial begin
    rst      = 1'b1;
    Sign     = 4'b0000;
    Para_Len = '0;
    S_Data   = '0;
    S_Valid  = 1'b0;
    clear_logs();
    test_reset();
    test_basic();
    test_gaps();
    test_zero_len();
    test_over_len();
    test_reset_abort();
    test_sign_during_load();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
